disp_scan6: RTL and testbench
=============================

Name: disp_scan6

Overview:
Multiplexed 6-digit common-anode 7-segment scanner for the digital clock. It consumes the six BCD digit outputs of the clock counters (hour tens/units, minute tens/units, second tens/units) and drives one shared segment bus plus six digit enables in time-division.
- Digits are snapshotted once per frame, so a frame never shows a mix of pre- and post-rollover values.
- Supports leading-zero blanking, per-digit blink for time-set mode, and anti-ghost dead time.

Parameters:
SCAN_DIV, 1000, in_clk cycles per digit slot (>= 2)
DEAD, 2, in_clk cycles at start of each slot with all digits off (< SCAN_DIV)
BLINK_FRAMES, 250, full frames per blink half-period (>= 1)

Ports:
in_clk  input  1  system clock
rst  input  1  asynchronous active-high reset
h2  input  4  hour tens BCD
h1  input  4  hour units BCD
m2  input  4  minute tens BCD
m1  input  4  minute units BCD
s2  input  4  second tens BCD
s1  input  4  second units BCD
blank_lz  input  1  1 = blank h2 when it is 0
blink_mask  input  6  bit i = digit slot i blinks
seg  output  7  {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
com  output  6  digit enable, active-low, bit i = slot i

Behaviour:
- Reset: rst is asynchronous and active-high, sampled against in_clk.
  - While rst is high: presc=0, slot=0, frame_cnt=0, blink_phase=0, snapshot digits all 0.
  - Outputs during reset: com=6'b111111, seg=7'b1111111, dp=1.
  - Assertion mid-frame forces these values immediately, without waiting for a clock edge.
- Slot order: 0=h2, 1=h1, 2=m2, 3=m1, 4=s2, 5=s1. Slot 0 is the leftmost digit.
- Prescaler: presc counts 0..SCAN_DIV-1 and wraps. tick = (presc == SCAN_DIV-1).
- Slot advance: on tick, slot advances 0→1→…→5→0.
- Frame wrap: on tick with slot==5:
  - snapshot <= {h2,h1,m2,m1,s2,s1}, sampled on that edge;
  - frame_cnt increments;
  - when frame_cnt==BLINK_FRAMES-1 it instead clears to 0 and blink_phase toggles.
- Snapshot contents: the first frame after reset displays the reset snapshot (all zeros, subject to blanking). Input changes mid-frame are not visible until the next frame.
- Digit decode, highest priority first:
  1. blank if blink_mask[slot] & blink_phase;
  2. blank if slot==0 & blank_lz & digit==0;
  3. dash (7'b0111111) if digit > 9;
  4. otherwise BCD pattern.
- BCD patterns (active-low):
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
  5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  blank=1111111.
- dp = 0 in slots 1 and 3 (HH.MM.SS separators) unless that slot is blanked; otherwise 1.
- Registered outputs: seg, dp and com are registered with 1 in_clk latency from the internal state (presc, slot, snapshot, blink_phase).
- Dead time: com = 6'b111111 whenever the registered-from presc < DEAD. Otherwise com = ~(1<<slot), exactly one bit low.
- Blanked slots: com is still driven low (enabled) with seg=1111111. Scan timing is identical regardless of content.
- Frame period: 6*SCAN_DIV cycles. Blink half-period: BLINK_FRAMES*6*SCAN_DIV cycles.

Test Plan:
(Simulation parameters: SCAN_DIV=4, DEAD=1, BLINK_FRAMES=2.)
- Reset/first frame: rst high 3 cycles, then low, inputs 1,2,3,4,5,6.
  -> com=111111, seg=1111111 during reset.
  -> First frame shows 0 in all slots; h2 slot 1111111 if blank_lz=1, else 1000000.
  -> Second frame shows 1000000? no: second frame shows 1111001,0100100,0110000,0011001,0010010,0000010.
  -> dp=0 only in slots 1 and 3.
- Scan timing: per slot exactly 1 cycle com=111111, then 3 cycles with a single low bit. Sequence is 111110,111101,…,011111, period 24 cycles.
- Frame coherence: change s1 from 9 to 0 and s2 from 5 to 0 while slot==2. -> Current frame still shows s2=5, s1=9; the next frame shows 0,0.
- Invalid BCD/blanking: h1=4'hC -> slot 1 seg=0111111. h2=0 with blank_lz=1 -> slot 0 seg=1111111 while com bit 0 is still low.
- Blink: blink_mask=6'b000011, h2=1, h1=2.
  -> Slots 0-1 alternate visible/blank every 2 frames (48 cycles); other slots are unaffected.
  -> dp stays 1 in slot 1 during blank frames.
- Async reset mid-slot: assert rst at slot 3, presc 2. -> Outputs go to reset values within the same cycle; on release, scanning restarts at slot 0 with the dead cycle.

Source files
------------

// File: rtl/disp_scan6.sv
// Six-digit multiplexed 7-segment scanner: frame-coherent digit snapshot, leading-zero blanking, blink, dead time.
// Latency: seg/dp/com are registered one in_clk after the scan state they decode.
module disp_scan6 #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEAD         = 2,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic [3:0] h2,
    input  logic [3:0] h1,
    input  logic [3:0] m2,
    input  logic [3:0] m1,
    input  logic [3:0] s2,
    input  logic [3:0] s1,
    input  logic       blank_lz,
    input  logic [5:0] blink_mask,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] com
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DEAD_P    = PW'(DEAD);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]     r_presc;
    logic [2:0]        r_slot;
    logic [FW-1:0]     r_frame_cnt;
    logic              r_blink_phase;
    logic [5:0][3:0]   r_snap;

    logic              w_tick;
    logic              w_frame_end;
    logic [3:0]        w_digit;
    logic              w_blank;
    logic [6:0]        w_seg;
    logic              w_dp;
    logic [5:0]        w_com;

    assign w_tick      = (r_presc == PRESC_MAX);
    assign w_frame_end = w_tick && (r_slot == 3'd5);

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            r_presc       <= '0;
            r_slot        <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_snap        <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_slot <= (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;
            end
            // Digits are latched only at the frame boundary so one frame never mixes old and new time.
            if (w_frame_end) begin
                r_snap <= {s1, s2, m1, m2, h1, h2};
                if (r_frame_cnt == FRAME_MAX) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_digit = r_snap[r_slot];
        w_blank = (blink_mask[r_slot] & r_blink_phase) |
                  ((r_slot == 3'd0) & blank_lz & (w_digit == 4'd0));
        w_seg   = 7'b1111111;
        if (!w_blank) begin
            case (w_digit)
                4'd0:    w_seg = 7'b1000000;
                4'd1:    w_seg = 7'b1111001;
                4'd2:    w_seg = 7'b0100100;
                4'd3:    w_seg = 7'b0110000;
                4'd4:    w_seg = 7'b0011001;
                4'd5:    w_seg = 7'b0010010;
                4'd6:    w_seg = 7'b0000010;
                4'd7:    w_seg = 7'b1111000;
                4'd8:    w_seg = 7'b0000000;
                4'd9:    w_seg = 7'b0010000;
                default: w_seg = 7'b0111111;
            endcase
        end
        w_dp  = ~(((r_slot == 3'd1) || (r_slot == 3'd3)) && !w_blank);
        // Blanked digits are still enabled so scan timing never depends on content.
        w_com = (r_presc < DEAD_P) ? 6'b111111 : ~(6'b000001 << r_slot);
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            seg <= 7'b1111111;
            dp  <= 1'b1;
            com <= 6'b111111;
        end else begin
            seg <= w_seg;
            dp  <= w_dp;
            com <= w_com;
        end
    end

endmodule

// File: tb/tb_disp_scan6.sv
// Bench for disp_scan6: arithmetic scan model compared every cycle, plus literal spot checks.
module tb_disp_scan6;

    localparam int SD = 4;
    localparam int DT = 1;
    localparam int BF = 2;
    localparam int FR = 6 * SD;

    logic       in_clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] h2, h1, m2, m1, s2, s1;
    logic       blank_lz;
    logic [5:0] blink_mask;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] com;

    disp_scan6 #(.SCAN_DIV(SD), .DEAD(DT), .BLINK_FRAMES(BF)) dut (
        .in_clk(in_clk), .rst(rst),
        .h2(h2), .h1(h1), .m2(m2), .m1(m1), .s2(s2), .s1(s1),
        .blank_lz(blank_lz), .blink_mask(blink_mask),
        .seg(seg), .dp(dp), .com(com)
    );

    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] bcd_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Model: output after edge k+1 reflects scan position k counted from reset release.
    int         n_edges = 0;
    logic [3:0] m_snap [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [6:0] exp_seg = 7'b1111111;
    logic       exp_dp  = 1'b1;
    logic [5:0] exp_com = 6'b111111;
    int         m_slot, m_presc, m_frame;
    logic [3:0] m_dig;
    logic       m_blank;

    always @(posedge in_clk) begin
        if (rst) begin
            n_edges = 0;
            m_snap  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
            exp_com = 6'b111111;
        end else begin
            m_presc = n_edges % SD;
            m_slot  = (n_edges / SD) % 6;
            m_frame = n_edges / FR;
            m_dig   = m_snap[m_slot];
            m_blank = (blink_mask[m_slot] && ((m_frame / BF) % 2 == 1)) ||
                      (m_slot == 0 && blank_lz && m_dig == 4'd0);
            if (m_blank)          exp_seg = 7'b1111111;
            else if (m_dig > 9)   exp_seg = 7'b0111111;
            else                  exp_seg = bcd_tbl[m_dig];
            exp_dp  = ((m_slot == 1 || m_slot == 3) && !m_blank) ? 1'b0 : 1'b1;
            exp_com = (m_presc < DT) ? 6'b111111 : ~(6'b000001 << m_slot);
            if (n_edges % FR == FR - 1) m_snap = '{h2, h1, m2, m1, s2, s1};
            n_edges++;
        end
    end

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge in_clk) begin
        if (rst) begin
            check("com_rst", {1'b0, com}, 7'b0111111);
            check("seg_rst", seg, 7'b1111111);
            check("dp_rst", {6'd0, dp}, 7'd1);
        end else begin
            check("com", {1'b0, com}, {1'b0, exp_com});
            check("seg", seg, exp_seg);
            check("dp", {6'd0, dp}, {6'd0, exp_dp});
        end
    end

    task automatic goto(input int idx);
        for (int k = 0; k < 3000; k++) begin
            @(negedge in_clk);
            if (n_edges - 1 == idx) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL goto_timeout: position %0d not reached, at %0d", idx, n_edges - 1);
    endtask

    int tgt;

    initial begin
        h2 = 4'd1; h1 = 4'd2; m2 = 4'd3; m1 = 4'd4; s2 = 4'd5; s1 = 4'd6;
        blank_lz = 1'b1;
        blink_mask = 6'b000000;
        #1 rst = 1'b1;
        repeat (3) @(posedge in_clk);
        @(negedge in_clk);
        check("lit_rst_com", {1'b0, com}, 7'b0111111);
        check("lit_rst_seg", seg, 7'b1111111);
        #2 rst = 1'b0;

        goto(0);
        check("lit_dead_com", {1'b0, com}, 7'b0111111);
        goto(1);
        check("lit_f0_com", {1'b0, com}, 7'b0111110);
        check("lit_f0_lz_seg", seg, 7'b1111111);
        goto(29);
        check("lit_f1_h1_seg", seg, 7'b0100100);
        check("lit_f1_h1_dp", {6'd0, dp}, 7'd0);
        check("lit_f1_h1_com", {1'b0, com}, 7'b0111101);
        s2 = 4'd5; s1 = 4'd9;

        goto(57);
        s2 = 4'd0; s1 = 4'd0;
        goto(69);
        check("lit_coh_old_s1", seg, 7'b0010000);
        goto(89);
        check("lit_coh_new_s2", seg, 7'b1000000);
        goto(93);
        check("lit_coh_new_s1", seg, 7'b1000000);
        h2 = 4'd0; h1 = 4'hC; blank_lz = 1'b1;

        goto(97);
        check("lit_lz_seg", seg, 7'b1111111);
        check("lit_lz_com", {1'b0, com}, 7'b0111110);
        goto(101);
        check("lit_dash_seg", seg, 7'b0111111);
        check("lit_dash_dp", {6'd0, dp}, 7'd0);
        h2 = 4'd1; h1 = 4'd2; blank_lz = 1'b0; blink_mask = 6'b000011;

        goto(121);
        check("lit_blink_on", seg, 7'b1111001);
        goto(145);
        check("lit_blink_off_seg", seg, 7'b1111111);
        check("lit_blink_off_com", {1'b0, com}, 7'b0111110);
        goto(149);
        check("lit_blink_off_dp", {6'd0, dp}, 7'd1);
        goto(153);
        check("lit_blink_m2", seg, 7'b0110000);
        goto(193);
        check("lit_blink_back", seg, 7'b1111001);

        for (int i = 0; i < 900; i++) begin
            @(negedge in_clk);
            if ($urandom_range(0, 3) == 0) begin
                h2 = 4'($urandom_range(0, 15)); h1 = 4'($urandom_range(0, 15));
                m2 = 4'($urandom_range(0, 15)); m1 = 4'($urandom_range(0, 15));
                s2 = 4'($urandom_range(0, 15)); s1 = 4'($urandom_range(0, 15));
                blank_lz = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 49) == 0) blink_mask = 6'($urandom_range(0, 63));
        end

        blink_mask = 6'b000000;
        tgt = ((n_edges - 1) / FR + 2) * FR + 14;
        goto(tgt);
        check("lit_pre_rst_com", {1'b0, com}, 7'b0110111);
        #2 rst = 1'b1;
        #1;
        check("lit_async_com", {1'b0, com}, 7'b0111111);
        check("lit_async_seg", seg, 7'b1111111);
        check("lit_async_dp", {6'd0, dp}, 7'd1);
        @(negedge in_clk);
        @(negedge in_clk);
        #2 rst = 1'b0;
        goto(0);
        check("lit_restart_dead", {1'b0, com}, 7'b0111111);
        goto(1);
        check("lit_restart_slot0", {1'b0, com}, 7'b0111110);
        goto(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
